// File: rtl/arb_pkg.sv
// Shared types and constants for the terminal injection arbiter.
package arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Width of each per-requester grant counter (stats build only).
  localparam int CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority pick: first eligible index at or after rr_ptr, wrapping.
// Works for any N_REQ, including non-powers of two.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDW-1:0]   rr_ptr,
  output logic             any,
  output logic [IDW-1:0]   winner
);

  // Scan from farthest to nearest so the index closest to rr_ptr wins last.
  always_comb begin
    int idx;
    any    = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (eligible[idx]) begin
        any    = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/terminal_injection_arbiter.sv
// Round-robin arbiter feeding one mesh terminal input from N_REQ show-ahead
// FIFOs. One registered output word; reloads on the same cycle it is consumed
// so a busy terminal sees one word per cycle.
// Optional: define ARB_STATS_EN to add saturating per-requester grant counters
// on output grant_cnt.
module terminal_injection_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int PAKG_SIZE = 32,
  parameter int IDW       = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_pndng,
  input  logic [N_REQ*PAKG_SIZE-1:0] req_data,
  output logic [N_REQ-1:0]           req_pop,
  input  logic [N_REQ-1:0]           req_en,
  output logic                       pndng_i_in,
  output logic [PAKG_SIZE-1:0]       data_out_i_in,
  input  logic                       popin,
  output logic [IDW-1:0]             grant_id,
  output logic                       err_popin
`ifdef ARB_STATS_EN
  ,
  output logic [N_REQ*CNT_W-1:0]     grant_cnt
`endif
);

  arb_state_e       state;
  logic [IDW-1:0]   rr_ptr;
  logic [N_REQ-1:0] eligible;
  logic [IDW-1:0]   ptr_inc;
  logic [IDW-1:0]   pick_ptr;
  logic             any;
  logic [IDW-1:0]   winner;
  logic             drain;
  logic             load;

  assign eligible = req_pndng & req_en;
  assign drain    = (state == HOLD) && popin;
  assign ptr_inc  = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  // A consumed word advances priority before the same-cycle reload picks.
  assign pick_ptr = drain ? ptr_inc : rr_ptr;
  // Reset wins over everything, so no pop can escape during reset.
  assign load     = !reset && any && ((state == IDLE) || popin);

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .eligible (eligible),
    .rr_ptr   (pick_ptr),
    .any      (any),
    .winner   (winner)
  );

  // Pop the winner in the same cycle its word is captured (show-ahead FIFO).
  always_comb begin
    req_pop = '0;
    if (load) req_pop[winner] = 1'b1;
  end

  // Output register, pointer and IDLE/HOLD state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pndng_i_in    <= 1'b0;
      data_out_i_in <= '0;
      grant_id      <= '0;
      rr_ptr        <= '0;
      err_popin     <= 1'b0;
    end else begin
      if (drain) rr_ptr <= ptr_inc;
      if (load) begin
        state         <= HOLD;
        pndng_i_in    <= 1'b1;
        data_out_i_in <= req_data[int'(winner)*PAKG_SIZE +: PAKG_SIZE];
        grant_id      <= winner;
      end else if (drain) begin
        state      <= IDLE;
        pndng_i_in <= 1'b0;
      end
      if ((state == IDLE) && popin) err_popin <= 1'b1;
    end
  end

`ifdef ARB_STATS_EN
  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
    // Saturating grant counter for requester i.
    always_ff @(posedge clk) begin
      if (reset)
        grant_cnt[i*CNT_W +: CNT_W] <= '0;
      else if (req_pop[i] && (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}}))
        grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_terminal_injection_arbiter.sv
// Bench for terminal_injection_arbiter: per-cycle vector table with a data
// scoreboard, a random property run, and the stats saturation case when
// ARB_STATS_EN is defined.
module tb_terminal_injection_arbiter;

  localparam int N  = 4;
  localparam int PW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_pndng;
  logic [N*PW-1:0] req_data;
  logic [N-1:0]    req_pop;
  logic [N-1:0]    req_en;
  logic            pndng_i_in;
  logic [PW-1:0]   data_out_i_in;
  logic            popin;
  logic [1:0]      grant_id;
  logic            err_popin;
`ifdef ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  terminal_injection_arbiter #(.N_REQ(N), .PAKG_SIZE(PW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_pndng     (req_pndng),
    .req_data      (req_data),
    .req_pop       (req_pop),
    .req_en        (req_en),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .popin         (popin),
    .grant_id      (grant_id),
    .err_popin     (err_popin)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt     (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [3:0] pnd;
    logic [3:0] en;
    logic       pin;
    logic [3:0] e_pop;
    logic       e_pnd;
    logic [1:0] e_gid;
    logic       e_err;
  } vec_t;

  vec_t          vecs[$];
  logic [PW-1:0] sb[$];
  int            errors = 0;
  int            checks = 0;

  function automatic logic [PW-1:0] data_of(int i);
    return {16'hA5A5, 16'(i)};
  endfunction

  function automatic int idx_of(logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic r, logic [3:0] p, logic [3:0] e, logic pi,
                              logic [3:0] ep, logic epn, logic [1:0] eg, logic ee);
    vec_t v;
    v = '{r, p, e, pi, ep, epn, eg, ee};
    return v;
  endfunction

  // Scoreboard step taken at the sampling point of a cycle.
  task automatic sb_step(string tag, logic held, logic consumed, logic [3:0] popped);
    if (held) begin
      if (sb.size() == 0) begin
        errors++; checks++;
        $display("FAIL %s: word held but scoreboard empty", tag);
      end else begin
        chk({tag, "_data"}, data_out_i_in, sb[0]);
        if (consumed) void'(sb.pop_front());
      end
    end
    if (popped != 0) sb.push_back(data_of(idx_of(popped)));
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_data[i*PW +: PW] = data_of(i);
    reset = 1'b1; req_pndng = '0; req_en = '0; popin = 1'b0;
    repeat (2) @(posedge clk);

    //            rst pnd    en     pin  e_pop  pnd gid   err
    vecs.push_back(mk(1, 4'hF, 4'hF, 1, 4'h0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h1, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h4, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h8, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h1, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 1, 4'h2, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'hF, 4'hB, 1, 4'h8, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'hF, 4'hB, 1, 4'h1, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'hF, 4'hB, 1, 4'h2, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'hF, 4'hB, 1, 4'h8, 1, 2'd1, 1));
    vecs.push_back(mk(0, 4'h4, 4'hF, 0, 4'h0, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'h4, 4'hF, 0, 4'h0, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'h4, 4'hF, 1, 4'h4, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 4'h0, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'h0, 4'h0, 0, 4'h0, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'h4, 4'h0, 0, 4'h0, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 4'h0, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h0, 1, 2'd2, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 4'h0, 0, 2'd2, 1));
    vecs.push_back(mk(0, 4'h8, 4'hF, 0, 4'h8, 0, 2'd2, 1));
    vecs.push_back(mk(1, 4'h8, 4'hF, 0, 4'h0, 1, 2'd3, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 4'h0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h1, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h0, 1, 2'd0, 0));
    vecs.push_back(mk(1, 4'h0, 4'hF, 0, 4'h0, 1, 2'd0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h0, 0, 2'd0, 0));
    vecs.push_back(mk(0, 4'h0, 4'hF, 0, 4'h0, 0, 2'd0, 1));
    vecs.push_back(mk(0, 4'hF, 4'hF, 0, 4'h1, 0, 2'd0, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h0, 1, 2'd0, 1));
    vecs.push_back(mk(0, 4'h0, 4'hF, 1, 4'h0, 0, 2'd0, 1));

    foreach (vecs[k]) begin
      string t;
      @(posedge clk); #1;
      reset = vecs[k].rst; req_pndng = vecs[k].pnd;
      req_en = vecs[k].en; popin = vecs[k].pin;
      @(negedge clk);
      t = $sformatf("v%0d", k);
      chk({t, "_pop"}, 32'(req_pop), 32'(vecs[k].e_pop));
      chk({t, "_pnd"}, 32'(pndng_i_in), 32'(vecs[k].e_pnd));
      chk({t, "_gid"}, 32'(grant_id), 32'(vecs[k].e_gid));
      chk({t, "_err"}, 32'(err_popin), 32'(vecs[k].e_err));
      sb_step(t, vecs[k].e_pnd, vecs[k].pin, vecs[k].rst ? 4'h0 : vecs[k].e_pop);
      if (vecs[k].rst) sb.delete();
    end

    // Random run: pops are one-hot, only to eligible requesters, and every
    // presented word matches the popped source in order.
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0; sb.delete();
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      req_pndng = 4'($urandom); req_en = 4'($urandom | 1); popin = 1'($urandom);
      @(negedge clk);
      chk("rnd_onehot", 32'($onehot0(req_pop)), 32'd1);
      chk("rnd_elig", 32'(req_pop & ~(req_pndng & req_en)), 32'd0);
      sb_step("rnd", pndng_i_in, popin, req_pop);
    end

    // Reset clears the output word.
    @(posedge clk); #1; reset = 1'b1; req_pndng = '0; popin = 1'b0;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_data", data_out_i_in, 32'h0);
    chk("rst_pnd", 32'(pndng_i_in), 32'd0);

`ifdef ARB_STATS_EN
    // Continuous grants to requester 1 saturate its counter.
    req_pndng = 4'h2; req_en = 4'hF; popin = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("cnt1_sat", 32'(grant_cnt[31:16]), 32'h0000_FFFF);
    chk("cnt0_zero", 32'(grant_cnt[15:0]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/terminal_injection_arbiter.md
TERMINAL_INJECTION_ARBITER -- requirements
Module: terminal_injection_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters sharing one mesh terminal input.
REQ-002 SHALL have parameter PAKG_SIZE, default 32: packet width in bits.
REQ-003 SHALL have parameter IDW, default $clog2(N_REQ): grant index width.
REQ-004 SHALL have port clk  in  1: single clock, rising-edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high.
REQ-006 SHALL have port req_pndng  in  N_REQ: per-requester word available (show-ahead FIFO pending).
REQ-007 SHALL have port req_data  in  N_REQ*PAKG_SIZE: flat bus; requester i occupies bits [i*PAKG_SIZE +: PAKG_SIZE], valid while req_pndng[i] is high.
REQ-008 SHALL have port req_pop  out  N_REQ: one-cycle pop pulse to the granted requester.
REQ-009 SHALL have port req_en  in  N_REQ: eligibility mask; a low bit excludes that requester.
REQ-010 SHALL have port pndng_i_in  out  1: word pending toward mesh terminal.
REQ-011 SHALL have port data_out_i_in  out  PAKG_SIZE: registered word toward mesh terminal.
REQ-012 SHALL have port popin  in  1: mesh consumed the presented word this cycle.
REQ-013 SHALL have port grant_id  out  IDW: source index of the word currently held.
REQ-014 SHALL have port err_popin  out  1: sticky flag, popin seen while pndng_i_in low.

Function
REQ-015 SHALL use two states: IDLE (output empty) and HOLD (word registered, pndng_i_in=1).
REQ-016 SHALL define eligible[i] = req_pndng[i] & req_en[i].
REQ-017 In IDLE with any eligible, SHALL select the first eligible index at or after rr_ptr, cyclically, pulse req_pop[winner], register req_data[winner] into data_out_i_in, set grant_id=winner, and enter HOLD next cycle.
REQ-018 SHALL give a one-cycle latency from eligible in IDLE to pndng_i_in high.
REQ-019 In HOLD, SHALL hold data_out_i_in, grant_id and pndng_i_in stable until popin.
REQ-020 In HOLD with popin, SHALL set rr_ptr=(grant_id+1) mod N_REQ; if any eligible, SHALL reload in the same cycle using the updated pointer and remain in HOLD, giving 1 word/cycle throughput; otherwise SHALL go to IDLE with pndng_i_in low next cycle.
REQ-021 SHALL assert at most one req_pop bit per cycle and never pop a requester whose eligible bit is low.
REQ-022 SHALL ignore req_en changes for a word already held.
REQ-023 On popin while in IDLE, SHALL set err_popin and otherwise take no action.
REQ-024 SHALL wrap rr_ptr from N_REQ-1 to 0; N_REQ need not be a power of two.
REQ-025 SHALL guarantee that each continuously eligible requester is granted within N_REQ grants.

Reset
REQ-026 On reset, SHALL next cycle set state=IDLE, pndng_i_in=0, data_out_i_in=0, grant_id=0, rr_ptr=0, req_pop=0 and err_popin=0.
REQ-027 Reset in HOLD SHALL discard the held word without re-popping its source.
REQ-028 Reset SHALL override popin and all request inputs in the same cycle.

Configuration
REQ-029 With ARB_STATS_EN defined, SHALL add output grant_cnt (N_REQ*16), one 16-bit counter per requester that increments on each req_pop, saturates at 16'hFFFF and clears on reset.
REQ-030 Without ARB_STATS_EN, SHALL have no grant_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-031 SHALL place the state enum (IDLE, HOLD) and the counter width constant (16) in the shared package arb_pkg.
REQ-032 SHALL implement the cyclic priority pick as a combinational sub-module rr_pick (inputs eligible and rr_ptr; outputs any and winner).

Verification
REQ-033 Reset with req_pndng=4'b1111, req_en=4'b1111, popin held 1 -> grant order 0,1,2,3,0 on consecutive cycles; pndng_i_in continuous from cycle 2.
REQ-034 Requester 2 only, data 32'hA5A5_0002, popin low for 5 cycles then high -> data_out_i_in stable for 5 cycles; a single req_pop[2] pulse; IDLE after the pop.
REQ-035 req_en=4'b1011 with all pending -> requester 2 is never popped; order 0,1,3,0.
REQ-036 popin=1 while idle after reset -> err_popin=1 and stays 1 until reset.
REQ-037 Reset asserted in HOLD with grant_id=3 -> pndng_i_in=0 and rr_ptr=0 next cycle; no req_pop during or after reset until new eligibility.
REQ-038 With ARB_STATS_EN defined, 70000 grants to requester 1 -> grant_cnt[31:16]=16'hFFFF.
